// File: rtl/digit_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// digit_scan_ctrl_if
// Bus between a host and the digit scan controller.
//   wr_en / wr_addr / wr_data : shadow-bank write port (data[4] = dp, [3:0] = value)
//   commit                    : request shadow -> display copy at next frame boundary
//   showDigit / showNum       : registered scan outputs toward the seven-segment decoder
//   pending / frame_done      : commit status and frame boundary pulse
// master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface digit_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       commit;
  logic [3:0] showDigit;
  logic [5:0] showNum;
  logic       pending;
  logic       frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  showDigit, showNum, pending, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output showDigit, showNum, pending, frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// digit_scan_ctrl
// Scan controller for a common-anode multi-digit seven-segment display.
// Each digit holds a 4-bit value plus a decimal point. Writes go to a shadow
// bank; a commit copies the whole shadow bank into the display bank at the
// next frame boundary so a frame never shows a mix of old and new data.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   bus        slave modport of digit_scan_ctrl_if:
//     wr_en, wr_addr, wr_data, commit  (in)
//     showDigit (1..DIGITS), showNum {dp,0,value}, pending, frame_done (out)
//
// Parameters
//   DIGITS    number of scanned digits, 1..8
//   PRESCALE  clk cycles per digit slot, >= 2
// ---------------------------------------------------------------------------
module digit_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  digit_scan_ctrl_if.slave  bus
);

  localparam int              CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [2:0]      SLOT_LAST = 3'(DIGITS - 1);
  localparam logic [3:0]      DIG_N     = 4'(DIGITS);
  localparam int unsigned     NDIG      = DIGITS;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    slot_q, slot_d;
  logic [3:0]    sd_q, sd_d;
  logic [5:0]    sn_q, sn_d;
  logic          pend_q, pend_d;
  logic          fd_q, fd_d;
  logic [4:0]    shadow_q  [8];
  logic [4:0]    shadow_d  [8];
  logic [4:0]    display_q [8];
  logic [4:0]    display_d [8];

  logic          tick;
  logic          boundary;
  logic          copy;
  logic [4:0]    next_entry;

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    boundary = tick && (slot_q == SLOT_LAST);
    copy     = boundary && pend_q;

    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    slot_d = slot_q;
    if (tick) begin
      slot_d = boundary ? '0 : slot_q + 3'd1;
    end

    // Copy reads the pre-write shadow, so a write on the boundary cycle
    // lands in the shadow bank only and shows up one commit later.
    display_d = display_q;
    if (copy) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        display_d[3'(i)] = shadow_q[3'(i)];
      end
    end

    shadow_d = shadow_q;
    if (bus.wr_en && ({1'b0, bus.wr_addr} < DIG_N)) begin
      shadow_d[bus.wr_addr] = bus.wr_data;
    end

    // A commit on the boundary cycle survives into the next frame.
    pend_d = bus.commit || (pend_q && !boundary);
    fd_d   = boundary;

    // Outputs load from display_d so slot 0 of a committing boundary
    // already shows the freshly copied data.
    next_entry = display_d[slot_d];
    sd_d       = sd_q;
    sn_d       = sn_q;
    if (tick) begin
      sd_d = {1'b0, slot_d} + 4'd1;
      sn_d = {next_entry[4], 1'b0, next_entry[3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      slot_q    <= '0;
      sd_q      <= 4'd1;
      sn_q      <= '0;
      pend_q    <= 1'b0;
      fd_q      <= 1'b0;
      shadow_q  <= '{default: '0};
      display_q <= '{default: '0};
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      sd_q      <= sd_d;
      sn_q      <= sn_d;
      pend_q    <= pend_d;
      fd_q      <= fd_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
    end
  end

  assign bus.showDigit  = sd_q;
  assign bus.showNum    = sn_q;
  assign bus.pending    = pend_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_digit_scan_ctrl
// Drives an 8-digit and a 6-digit controller (PRESCALE=4) with the same
// stimulus and compares every output each cycle against a model that derives
// the scan position from elapsed cycles since reset.
// ---------------------------------------------------------------------------
module tb_digit_scan_ctrl;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       commit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl_if bus8 ();
  digit_scan_ctrl_if bus6 ();

  assign bus8.wr_en   = wr_en;
  assign bus8.wr_addr = wr_addr;
  assign bus8.wr_data = wr_data;
  assign bus8.commit  = commit;
  assign bus6.wr_en   = wr_en;
  assign bus6.wr_addr = wr_addr;
  assign bus6.wr_data = wr_data;
  assign bus6.commit  = commit;

  digit_scan_ctrl #(.DIGITS(8), .PRESCALE(P)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  digit_scan_ctrl #(.DIGITS(6), .PRESCALE(P)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  // Reference model, one entry per DUT (0: 8 digits, 1: 6 digits).
  int         mdn   [2] = '{8, 6};
  logic [4:0] msh   [2][8];
  logic [4:0] mdisp [2][8];
  bit         mpend [2];
  bit         mfd   [2];
  int         mt    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Effect of one posedge on the model, given the inputs currently driven.
  task automatic model_edge(input int u);
    int         dn;
    bit         bnd;
    logic [4:0] pre [8];
    dn = mdn[u];
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        msh[u][i]   = '0;
        mdisp[u][i] = '0;
      end
      mpend[u] = 0;
      mfd[u]   = 0;
      mt[u]    = 0;
      return;
    end
    bnd = (mt[u] % P == P - 1) && ((mt[u] / P) % dn == dn - 1);
    for (int i = 0; i < 8; i++) pre[i] = msh[u][i];
    if (bnd && mpend[u])
      for (int i = 0; i < dn; i++) mdisp[u][i] = pre[i];
    mpend[u] = commit || (mpend[u] && !bnd);
    if (wr_en && int'(wr_addr) < dn) msh[u][wr_addr] = wr_data;
    mfd[u] = bnd;
    mt[u]++;
  endtask

  task automatic compare(input int u, input logic [3:0] sd, input logic [5:0] sn,
                         input logic pd, input logic fd);
    int         s;
    logic [4:0] e;
    s = (mt[u] / P) % mdn[u];
    e = mdisp[u][s];
    check($sformatf("u%0d.showDigit", u), 32'(sd), 32'(s + 1));
    check($sformatf("u%0d.showNum", u), 32'(sn), 32'({e[4], 1'b0, e[3:0]}));
    check($sformatf("u%0d.pending", u), 32'(pd), 32'(mpend[u]));
    check($sformatf("u%0d.frame_done", u), 32'(fd), 32'(mfd[u]));
  endtask

  task automatic cycle();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare(0, bus8.showDigit, bus8.showNum, bus8.pending, bus8.frame_done);
    compare(1, bus6.showDigit, bus6.showNum, bus6.pending, bus6.frame_done);
  endtask

  task automatic idle(input int n);
    wr_en  = 1'b0;
    commit = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [2:0] a, input logic [4:0] d, input logic c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    commit  = c;
    cycle();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  initial begin
    bit seen;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;

    // Reset held 3 cycles, then free-running scan over several frames.
    for (int i = 0; i < 3; i++) cycle();
    check("reset.showDigit", 32'(bus8.showDigit), 32'd1);
    check("reset.showNum", 32'(bus8.showNum), 32'd0);
    rst_n = 1'b1;
    idle(70);

    // Shadow[2] = 0x17 with commit mid-frame, then look for it on digit 3.
    idle(5);
    write(3'd2, 5'h17, 1'b1);
    check("commit.pending", 32'(bus8.pending), 32'd1);
    idle(70);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus8.showDigit == 4'd3) begin
        check("digit3.showNum", 32'(bus8.showNum), 32'h27);
        seen = 1;
      end
      if (!seen) cycle();
    end
    check("digit3.seen", 32'(seen), 32'd1);

    // Write without commit: display must stay put across 3 frames.
    write(3'd1, 5'h09, 1'b0);
    idle(96);

    // Pending commit, then a write plus commit exactly on the boundary cycle.
    write(3'd0, 5'h1A, 1'b1);
    write(3'd5, 5'h03, 1'b0);
    seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (mt[0] % 32 == 31) seen = 1;
      else idle(1);
    end
    check("boundary.reached", 32'(seen), 32'd1);
    check("boundary.pending_before", 32'(bus8.pending), 32'd1);
    write(3'd4, 5'h0B, 1'b1);
    check("boundary.pending_after", 32'(bus8.pending), 32'd1);
    idle(70);

    // Out-of-range addresses for the 6-digit instance.
    write(3'd7, 5'h1F, 1'b1);
    write(3'd6, 5'h15, 1'b1);
    idle(70);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 5'($urandom);
      commit  = ($urandom_range(0, 24) == 0);
      cycle();
    end
    rst_n = 1'b1;
    idle(10);

    // Reset mid-frame with a commit pending: no copy may follow.
    write(3'd3, 5'h12, 1'b1);
    idle(6);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("midrst.showDigit", 32'(bus8.showDigit), 32'd1);
    check("midrst.showNum", 32'(bus8.showNum), 32'd0);
    check("midrst.pending", 32'(bus8.pending), 32'd0);
    write(3'd3, 5'h12, 1'b0);
    idle(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
